// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through: dout always shows the head entry.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need a known state.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, TX FIFO, bit-serial FSM.
// Define UART_TX_IRQ_EN to add the registered drain interrupt output irq.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 50_000_000,
  parameter int          BAUD        = 115_200,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(DIV);

  tx_state_e     state;
  tx_state_e     state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;
  logic          pop;

  logic          hit;
  logic [2:0]    ofs;
  logic          wr_txdata;
  logic          wr_status;
  logic          ovf;
  logic          busy;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic [31:0]   status;
  logic          unused_bits;

  // Bus decode: the low two address bits select nothing, so byte lanes alias.
  assign hit       = (addr[31:3] == BASE_ADDR[31:3]);
  assign ofs       = {addr[2], 2'b00};
  assign wr_txdata = we && hit && (ofs == TXDATA_OFS);
  assign wr_status = we && hit && (ofs == STATUS_OFS);
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign busy = (state != IDLE);

  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf;
  end

  assign rdata = (re && hit && (ofs == STATUS_OFS)) ? status : 32'h0;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // A write that finds the FIFO full is lost even if a pop frees a slot on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            ovf <= 1'b0;
    else if (wr_txdata && full)            ovf <= 1'b1;
    else if (wr_status && wdata[ST_OVF])   ovf <= 1'b0;
  end

  assign bit_end = (baud_cnt == CW'(DIV - 1));

  // NOTE: non-blocking assignments for every registered signal, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults are assigned first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if ((state == IDLE) || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + CW'(1);

      if ((state == START) && bit_end)     bit_idx <= '0;
      else if ((state == DATA) && bit_end) bit_idx <= bit_idx + 3'd1;

      if (pop)                             shift <= head;
      else if ((state == DATA) && bit_end) shift <= {1'b0, shift[7:1]};
    end
  end

  // Line is decoded straight from state so an asynchronous reset idles it at once.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= empty && !busy;
  end
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: line decoder plus FIFO/status reference model.
module tb_uart_tx_mmio;

  localparam int          DIV   = 16;
  localparam int          DEPTH = 4;
  localparam int          FL    = 10 * DIV;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  uart_tx_mmio #(
    .CLK_FREQ_HZ (16),
    .BAUD        (1),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: one frame = 10 bit windows of DIV cycles, start bit 0, stop bit 1.
  bit         in_frame  = 1'b0;
  int         k         = 0;
  int         n_started = 0;
  int         cur       = 0;
  logic       samp [FL];
  int         rec_start [64];
  bit         rec_done  [64];
  logic [7:0] rec_byte  [64];
  int         rec_bad   [64];
  int         m_bad;
  logic [7:0] m_byte;
  logic       m_mid;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        k        = 0;
      end else begin
        if (in_frame && k < FL) begin
          samp[k] = tx;
          k++;
        end else if (in_frame) begin
          m_bad  = 0;
          m_byte = '0;
          for (int bi = 0; bi < 10; bi++) begin
            m_mid = samp[bi*DIV + DIV/2];
            for (int j = 0; j < DIV; j++)
              if (samp[bi*DIV + j] !== m_mid) m_bad++;
            if (bi >= 1 && bi <= 8) m_byte[bi-1] = m_mid;
            if (bi == 0 && m_mid !== 1'b0) m_bad++;
            if (bi == 9 && m_mid !== 1'b1) m_bad++;
          end
          if (cur < 64) begin
            rec_byte[cur] = m_byte;
            rec_bad[cur]  = m_bad;
            rec_done[cur] = 1'b1;
          end
          in_frame = 1'b0;
        end
        if (!in_frame && tx === 1'b0) begin
          cur = n_started;
          if (cur < 64) rec_start[cur] = cyc;
          n_started++;
          in_frame = 1'b1;
          samp[0]  = 1'b0;
          k        = 1;
        end
      end
    end
  end

  // Reference model: bytes accepted into the FIFO, in order, plus the sticky overflow flag.
  logic [7:0] acc [256];
  int         n_acc     = 0;
  int         acc_off   = 0;
  int         frame_off = 0;
  int         chk       = 0;
  bit         ovf_m     = 1'b0;
  int         last_w_cyc = 0;
  int         drain_cyc  = 0;
  int         checks   = 0;
  int         failures = 0;

  function automatic int pending();
    return (n_acc - acc_off) - (n_started - frame_off);
  endfunction

  function automatic logic [31:0] status_m();
    int p;
    p = pending();
    return {28'b0, ovf_m, in_frame, (p == 0), (p == DEPTH)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    if (a[31:3] == BASE[31:3] && !a[2]) begin
      if (pending() < DEPTH) begin
        acc[n_acc] = d[7:0];
        n_acc++;
      end else begin
        ovf_m = 1'b1;
      end
    end else if (a[31:3] == BASE[31:3] && a[2] && d[3]) begin
      ovf_m = 1'b0;
    end
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; addr = '0; wdata = '0;
    last_w_cyc = cyc;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); #1;
    re = 1'b1; addr = a;
    #1 d = rdata;
    #1 re = 1'b0; addr = '0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(BASE + 32'h4, d);
    check(tag, d, status_m());
  endtask

  task automatic check_frames();
    int ai;
    while (chk < n_started && chk < 64 && rec_done[chk]) begin
      ai = chk - frame_off + acc_off;
      check("frame_expected", 32'(ai < n_acc), 32'd1);
      if (ai < n_acc) check("frame_byte", 32'(rec_byte[chk]), 32'(acc[ai]));
      check("frame_shape", rec_bad[chk], 0);
      chk++;
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n = 0;
    while (n_started < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 32'(n_started >= target), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((pending() != 0 || in_frame) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 32'(pending() == 0 && !in_frame), 32'd1);
    drain_cyc = cyc;
    check_frames();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int t;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
`ifdef UART_TX_IRQ_EN
    check("reset_irq", 32'(irq), 32'd0);
`endif
    #1 rst_n = 1'b1;
    bus_read(BASE + 32'h4, d);
    check("reset_status", d, 32'h2);
`ifdef UART_TX_IRQ_EN
    check("irq_after_reset", 32'(irq), 32'd1);
`endif

    // 1: single 0xA5 frame, latency and busy duration
    t = n_started;
    bus_write(BASE, 32'hA5);
    bus_read(BASE + 32'h4, d);
    check("t1_status_queued", d, status_m());
`ifdef UART_TX_IRQ_EN
    check("t1_irq_before_drop", 32'(irq), 32'd1);
`endif
    wait_starts(t + 1, 40, "t1_start_seen");
    check("t1_latency", rec_start[t] - last_w_cyc, 1);
`ifdef UART_TX_IRQ_EN
    check("t1_irq_low", 32'(irq), 32'd0);
`endif
    check_status("t1_status_busy");
    wait_drain(FL + 40, "t1_drain");
    check("t1_busy_len", drain_cyc - rec_start[t], FL);
`ifdef UART_TX_IRQ_EN
    check("t1_irq_at_idle", 32'(irq), 32'd0);
    @(negedge clk); #1;
    check("t1_irq_back", 32'(irq), 32'd1);
`endif
    bus_read(BASE + 32'h4, d);
    check("t1_status_idle", d, 32'h2);

    // 2: three back-to-back frames
    t = n_started;
    for (int i = 0; i < 3; i++) bus_write(BASE, 32'($urandom_range(0, 255)));
    wait_starts(t + 3, 3 * FL + 40, "t2_starts");
    bus_read(BASE + 32'h4, d);
    check("t2_empty_busy", d, 32'h6);
    check("t2_status_model", d, status_m());
    wait_drain(FL + 40, "t2_drain");
    check("t2_gap01", rec_start[t+1] - rec_start[t], FL);
    check("t2_gap12", rec_start[t+2] - rec_start[t+1], FL);
    check("t2_total", drain_cyc - rec_start[t], 3 * FL);

    // 3: overflow while busy, then clear
    t = n_started;
    bus_write(BASE, 32'($urandom_range(0, 255)));
    wait_starts(t + 1, 40, "t3_start");
    for (int i = 0; i < 6; i++) bus_write(BASE, 32'($urandom_range(0, 255)));
    bus_read(BASE + 32'h4, d);
    check("t3_ovf_full", d, 32'hD);
    check("t3_status_model", d, status_m());
    bus_write(BASE + 32'h4, 32'h8);
    bus_read(BASE + 32'h4, d);
    check("t3_ovf_cleared", d, 32'h5);
    wait_drain(6 * FL, "t3_drain");
    check("t3_frames", n_started - t, 5);

    // 4: reset during data bit 3
    t = n_started;
    b = 8'($urandom_range(0, 255)) & 8'hF7;
    bus_write(BASE, 32'(b));
    bus_write(BASE, 32'($urandom_range(0, 255)));
    wait_starts(t + 1, 40, "t4_start");
    repeat (70) @(negedge clk);
    #1 check("t4_tx_bit3_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1 check("t4_tx_reset_high", 32'(tx), 32'd1);
`ifdef UART_TX_IRQ_EN
    check("t4_irq_reset", 32'(irq), 32'd0);
`endif
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    acc_off   = n_acc;
    frame_off = n_started;
    chk       = n_started;
    ovf_m     = 1'b0;
    bus_read(BASE + 32'h4, d);
    check("t4_status_after", d, 32'h2);
    repeat (3 * FL) @(negedge clk);
    check("t4_no_frame", n_started - frame_off, 0);

    // 5: misses, unmapped offset, read-enable gating, address aliasing
    t = n_started;
    bus_read(BASE + 32'h8, d);
    check("t5_unmapped_read", d, 32'h0);
    bus_read(32'h2000_0004, d);
    check("t5_miss_read", d, 32'h0);
    bus_write(BASE + 32'h8, 32'($urandom_range(0, 255)));
    bus_write(32'h2000_0000, 32'($urandom_range(0, 255)));
    bus_write(32'h2000_0004, 32'h8);
    bus_read(BASE, d);
    check("t5_txdata_read", d, 32'h0);
    @(negedge clk); #1;
    addr = BASE + 32'h4;
    #1 check("t5_re_low", rdata, 32'h0);
    addr = '0;
    bus_read(BASE + 32'h7, d);
    check("t5_alias_status", d, 32'h2);
    repeat (2 * FL) @(negedge clk);
    check("t5_no_frame", n_started - t, 0);
    bus_write(BASE + 32'h3, 32'($urandom_range(0, 255)));
    wait_drain(FL + 40, "t5_drain");
    check("t5_alias_frame", n_started - t, 1);

    // Random traffic against the model
    for (int i = 0; i < 8; i++) begin
      bus_write(BASE, $urandom);
      repeat ($urandom_range(0, 2 * FL)) @(negedge clk);
      if (i % 3 == 0) check_status("rand_status");
    end
    check_status("rand_status_end");
    bus_write(BASE + 32'h4, 32'h8);
    wait_drain((DEPTH + 2) * FL, "rand_drain");
    check_status("rand_status_idle");

    check("frames_accounted", n_started - frame_off, n_acc - acc_off);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
